// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types and constants for the sequential radix-2 Booth
//                multiplier: FSM state encoding, Booth pair codes and a
//                constant clog2 helper used to size the iteration counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Booth recoding of {q[0], q_1}
    localparam logic [1:0] BP_ADD = 2'b01;
    localparam logic [1:0] BP_SUB = 2'b10;

    // Ceiling log2 for elaboration-time sizing; bounded loop so it stays constant-foldable
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
//  Module      : booth_step
//  Description : One combinational radix-2 Booth iteration. Adds or subtracts
//                the multiplicand according to {q[0], q_1}, then shifts the
//                whole {acc, q, q_1} register right arithmetically by one.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_step
    import booth_pkg::*;
#(
    parameter int E = 32
) (
    input  logic [E:0]   acc,
    input  logic [E-1:0] q,
    input  logic         q_1,
    input  logic [E:0]   m,
    output logic [E:0]   acc_next,
    output logic [E-1:0] q_next,
    output logic         q_1_next
);

    logic [E:0] sum;

    // Conditional add/subtract of the multiplicand followed by the arithmetic shift
    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            BP_ADD:  sum = acc + m;
            BP_SUB:  sum = acc - m;
            default: sum = acc;
        endcase
        acc_next = {sum[E], sum[E:1]};
        q_next   = {sum[0], q[E-1:1]};
        q_1_next = q[0];
    end

endmodule
`default_nettype wire

// File: rtl/booth_mult.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult
//  Description : Sequential radix-2 Booth multiplier, one Booth step per clock.
//                W-bit operands in, 2W-bit product out with a one-cycle done
//                pulse. Optional feature macro BOOTH_UNSIGNED_EN adds the sgn
//                port and widens the datapath by one bit so unsigned operands
//                can be handled (zero-extended when sgn=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mult
    import booth_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef BOOTH_UNSIGNED_EN
    input  logic           sgn,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    // E is the extended operand width; the iteration count equals E
`ifdef BOOTH_UNSIGNED_EN
    localparam int E = W + 1;
`else
    localparam int E = W;
`endif
    localparam int N  = E;
    localparam int CW = clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state;
    state_t          state_next;

    logic [E:0]      acc;
    logic [E-1:0]    q;
    logic            q_1;
    logic [E:0]      m;
    logic [CW-1:0]   cnt;

    logic [E:0]      acc_next;
    logic [E-1:0]    q_next;
    logic            q_1_next;

    logic [E:0]      m_load;
    logic [E-1:0]    q_load;
    logic [2*E:0]    prod_full;
    logic            unused_bits;

    logic            accept;
    logic            last_iter;

`ifdef BOOTH_UNSIGNED_EN
    logic            a_ext;
    logic            b_ext;
    assign a_ext  = sgn & a[W-1];
    assign b_ext  = sgn & b[W-1];
    assign m_load = {a_ext, a_ext, a};
    assign q_load = {b_ext, b};
`else
    assign m_load = {a[W-1], a};
    assign q_load = b;
`endif

    assign accept    = (state == ST_IDLE) && start;
    assign last_iter = (cnt == LAST);
    assign busy      = (state == ST_RUN);

    // Final result is taken from the step output so done and p land on the last iteration edge
    assign prod_full   = {acc_next, q_next};
    assign unused_bits = ^prod_full[2*E:2*W];

    booth_step #(
        .E (E)
    ) u_step (
        .acc      (acc),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .acc_next (acc_next),
        .q_next   (q_next),
        .q_1_next (q_1_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, RUN exits after the last iteration
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)     state_next = ST_RUN;
            ST_RUN:  if (last_iter) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand load, Booth iteration, counter and product/done output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            q    <= '0;
            q_1  <= 1'b0;
            m    <= '0;
            cnt  <= '0;
            p    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                m   <= m_load;
                q   <= q_load;
                acc <= '0;
                q_1 <= 1'b0;
                cnt <= '0;
            end else if (state == ST_RUN) begin
                acc <= acc_next;
                q   <= q_next;
                q_1 <= q_1_next;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    p    <= prod_full[2*W-1:0];
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mult
//  Description : Self-checking bench for booth_mult at W=8. Table vectors and
//                random vectors feed a scoreboard queue; a monitor pops and
//                compares product, latency and busy length on every done.
//                Hand sequences cover back-to-back start, start during RUN
//                and reset in the middle of an operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult;

    localparam int W = 8;
`ifdef BOOTH_UNSIGNED_EN
    localparam int N       = W + 1;
    localparam bit HAS_SGN = 1'b1;
`else
    localparam int N       = W;
    localparam bit HAS_SGN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    typedef struct {
        logic [15:0] exp;
        int          acc_cyc;
    } sb_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[10];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int accepted = 0;
    int busy_run = 0;
    int last_done_cyc = -1;

    always #5 clk = ~clk;

    booth_mult #(
        .W (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef BOOTH_UNSIGNED_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        longint ex, ey, pr;
        ex = s ? longint'($signed(x)) : longint'(x);
        ey = s ? longint'($signed(y)) : longint'(y);
        pr = ex * ey;
        return pr[15:0];
    endfunction

    // Scoreboard monitor: sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (rst) begin
            busy_run = 0;
        end else if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            check("busy_low_at_done", 32'(busy), 32'd0);
            check("busy_cycles", 32'(busy_run), 32'(N));
            busy_run = 0;
            if (sb.size() == 0) begin
                check("sb_nonempty_at_done", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("product", 32'(p), 32'(e.exp));
                check("latency", 32'(cyc - e.acc_cyc), 32'(N));
            end
        end else if (busy) begin
            busy_run++;
        end
    end

    // Drive one request; the accept edge is the next rising edge
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [15:0] exp);
        sb_t e;
        @(negedge clk);
        a = x;
        b = y;
        sgn = s;
        start = 1'b1;
        e.exp = exp;
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        accepted++;
        @(negedge clk);
        start = 1'b0;
        a = ~x;
        b = ~y;
        sgn = ~s;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_dones(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        logic [7:0] rx, ry;
        logic rs;

        tbl[0] = '{8'h03, 8'h05, 1'b1, 16'h000F};
        tbl[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        tbl[2] = '{8'hF9, 8'h06, 1'b1, 16'hFFD6};
        tbl[3] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        tbl[4] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        tbl[6] = '{8'h00, 8'h55, 1'b1, 16'h0000};
        tbl[7] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        tbl[8] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        tbl[9] = '{8'h80, 8'h02, 1'b0, 16'h0100};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        sgn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_p", 32'(p), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            if (!HAS_SGN && !tbl[i].s) continue;
            issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp);
            wait_dones(accepted);
        end

        // Start during the done cycle is accepted with no dead cycle
        issue(8'hF9, 8'h06, 1'b1, 16'hFFD6);
        wait_dones(accepted);
        first_done = last_done_cyc;
        issue(8'h06, 8'hF9, 1'b1, 16'hFFD6);
        wait_dones(accepted);
        check("b2b_spacing", 32'(last_done_cyc - first_done), 32'(N + 1));

        // Start while RUN must be ignored
        issue(8'h02, 8'h02, 1'b1, 16'h0004);
        repeat (3) @(negedge clk);
        a = 8'h09;
        b = 8'h09;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dones(accepted);
        repeat (N + 4) @(negedge clk);
        check("no_extra_done", 32'(done_cnt), 32'(accepted));
        check("held_p", 32'(p), 32'h0004);
        check("idle_busy", 32'(busy), 32'd0);

        // Reset at the fourth edge of an operation discards it
        issue(8'h05, 8'h03, 1'b1, 16'h000F);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_p", 32'(p), 32'd0);
        accepted -= sb.size();
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(8'h01, 8'h01, 1'b1, 16'h0001);
        wait_dones(accepted);

        // Random vectors against the reference model
        for (int i = 0; i < 8; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rs = HAS_SGN ? 1'($urandom) : 1'b1;
            issue(rx, ry, rs, model(rx, ry, rs));
            wait_dones(accepted);
        end

        repeat (3) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'(accepted));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
